// File: rtl/mul_div_pkg.sv
// Shared definitions for the multi-cycle signed multiply/divide unit.
//   state_t   : FSM state encoding (IDLE -> RUN -> FIX -> DONE -> IDLE)
//   OP_MUL/DIV: encoding of the Op input
//   WIDTH_DEF : default operand width
package mul_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned WIDTH_DEF = 32;

endpackage

// File: rtl/mul_div_iter.sv
// Single-iteration combinational datapath shared by MUL and DIV.
//   op        : OP_MUL (Booth radix-2 step) or OP_DIV (restoring step)
//   acc_hi    : MUL: P_hi (WIDTH+1, signed) / DIV: partial remainder R
//   acc_lo    : MUL: P_lo / DIV: quotient-in-progress Q (dividend bits shift out)
//   q_m1      : Booth q_-1 bit (unused for DIV)
//   opnd      : MUL: sign-extended A / DIV: zero-extended |B|
//   nxt_*     : accumulator state after this iteration
module mul_div_iter
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             q_m1,
  input  logic [WIDTH:0]   opnd,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             nxt_q_m1
);

  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    booth_sum = acc_hi;
    r_sh      = '0;
    trial     = '0;
    nxt_hi    = acc_hi;
    nxt_lo    = acc_lo;
    nxt_q_m1  = 1'b0;

    if (op == OP_MUL) begin
      unique case ({acc_lo[0], q_m1})
        2'b01:   booth_sum = acc_hi + opnd;
        2'b10:   booth_sum = acc_hi - opnd;
        default: booth_sum = acc_hi;
      endcase
      // Arithmetic right shift of {P_hi, P_lo, q_-1}
      nxt_hi   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      nxt_lo   = {booth_sum[0], acc_lo[WIDTH-1:1]};
      nxt_q_m1 = acc_lo[0];
    end else begin
      // R < |B| <= 2^(WIDTH-1), so the shifted remainder fits in WIDTH bits
      // and bit WIDTH of the trial difference is a valid sign.
      r_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      trial = r_sh - opnd;
      if (!trial[WIDTH]) begin
        nxt_hi = trial;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = r_sh;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit feeding the Z register.
//   Clock   : rising-edge clock
//   Clear   : synchronous active-high reset, highest priority
//   Start   : request, sampled only in IDLE
//   Op      : 0 = MUL, 1 = DIV
//   A, B    : signed operands (latched at accept)
//   Busy    : high from accept until Done drops
//   Done    : one-cycle pulse, Result valid
//   DivZero : set with Done on DIV by zero, held until next accept
//   Result  : MUL {HI,LO} product / DIV {remainder, quotient}
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Start,
  input  logic               Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic               DivZero,
  output logic [2*WIDTH-1:0] Result
);

  state_t state, next_state;

  logic [CNT_W-1:0] cnt;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             q_m1;
  logic [WIDTH:0]   opnd;
  logic             div_zero;
  logic [2*WIDTH-1:0] result;

  logic [WIDTH:0]   nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic             nxt_q_m1;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1)
  // which is still representable as an unsigned WIDTH-bit value.
  always_comb begin
    mag_a = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    mag_b = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  end

  // Sign fix-up for truncating division
  always_comb begin
    quot_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~acc_lo + WIDTH'(1)) : acc_lo;
    rem_fix  = a_q[WIDTH-1] ? (~acc_hi[WIDTH-1:0] + WIDTH'(1)) : acc_hi[WIDTH-1:0];
  end

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .op       (op_q),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .q_m1     (q_m1),
    .opnd     (opnd),
    .nxt_hi   (nxt_hi),
    .nxt_lo   (nxt_lo),
    .nxt_q_m1 (nxt_q_m1)
  );

  always_ff @(posedge Clock) begin
    if (Clear) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (Start) next_state = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) next_state = S_FIX;
      S_FIX:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      cnt      <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      q_m1     <= 1'b0;
      opnd     <= '0;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            cnt      <= '0;
            op_q     <= Op;
            a_q      <= A;
            b_q      <= B;
            acc_hi   <= '0;
            q_m1     <= 1'b0;
            div_zero <= 1'b0;
            if (Op == OP_DIV) begin
              acc_lo <= mag_a;
              opnd   <= {1'b0, mag_b};
            end else begin
              acc_lo <= B;
              opnd   <= {A[WIDTH-1], A};
            end
          end
        end
        S_RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          q_m1   <= nxt_q_m1;
          cnt    <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (op_q == OP_MUL) begin
            result <= {acc_hi[WIDTH-1:0], acc_lo};
          end else if (b_q == '0) begin
            result   <= {a_q, {WIDTH{1'b1}}};
            div_zero <= 1'b1;
          end else begin
            result <= {rem_fix, quot_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state != S_IDLE);
  assign Done    = (state == S_DONE);
  assign DivZero = div_zero;
  assign Result  = result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        Clock;
  logic        Clear;
  logic        Start;
  logic        Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [63:0] Result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Result  (Result)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Full operation: accept, 32 iterations, FIX, DONE, back to IDLE.
  task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_r, input logic exp_dz);
    int busy_cycles;
    int early_done;
    busy_cycles = 0;
    early_done  = 0;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clock); #1;
    check({tag, "_busy_accept"}, {63'd0, Busy}, 64'd1);
    check({tag, "_dz_accept"}, {63'd0, DivZero}, 64'd0);
    if (Busy) busy_cycles++;
    Start = 1'b0;
    A = $urandom; B = $urandom;   // operand changes after accept must not matter
    for (int i = 1; i <= 32; i++) begin
      @(posedge Clock); #1;
      if (Busy) busy_cycles++;
      if (Done) early_done++;
    end
    check({tag, "_no_early_done"}, 64'(early_done), 64'd0);
    @(posedge Clock); #1;
    if (Busy) busy_cycles++;
    check({tag, "_done"}, {63'd0, Done}, 64'd1);
    check({tag, "_result"}, Result, exp_r);
    check({tag, "_divzero"}, {63'd0, DivZero}, {63'd0, exp_dz});
    @(posedge Clock); #1;
    check({tag, "_done_drop"}, {62'd0, Done, Busy}, 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd34);
    check({tag, "_result_hold"}, Result, exp_r);
  endtask

  initial begin
    int done_cnt;
    Clear = 1'b1; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_done", {63'd0, Done}, 64'd0);
    check("reset_dz", {63'd0, DivZero}, 64'd0);
    check("reset_result", Result, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;

    do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    do_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    do_op("mul_m1_1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    do_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    do_op("div_100_7", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    do_op("div_5_0", 1'b1, 32'd5, 32'd0, {32'h00000005, 32'hFFFFFFFF}, 1'b1);
    repeat (2) @(posedge Clock);
    #1;
    check("divzero_held_idle", {63'd0, DivZero}, 64'd1);
    do_op("mul_after_dz", 1'b0, 32'd3, 32'd5, 64'd15, 1'b0);
    do_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);

    // Clear 10 cycles into a MUL
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; A = 32'd9; B = 32'd9;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock); #1;
    check("clr_busy", {63'd0, Busy}, 64'd0);
    check("clr_result", Result, 64'd0);
    check("clr_done", {63'd0, Done}, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge Clock); #1;
      if (Done) done_cnt++;
    end
    check("clr_no_done", 64'(done_cnt), 64'd0);

    // Start and Clear on the same edge: Clear wins
    @(negedge Clock);
    Start = 1'b1; Clear = 1'b1;
    @(posedge Clock); #1;
    check("start_clr_same", {63'd0, Busy}, 64'd0);
    @(negedge Clock);
    Start = 1'b0; Clear = 1'b0;

    // Start pulsed mid-RUN is ignored: exactly one Done
    @(negedge Clock);
    Start = 1'b1; Op = 1'b1; A = 32'd100; B = 32'd7;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    Start = 1'b1; Op = 1'b0; A = 32'd2; B = 32'd2;
    @(negedge Clock);
    Start = 1'b0;
    done_cnt = 0;
    repeat (45) begin
      @(posedge Clock); #1;
      if (Done) done_cnt++;
    end
    check("midrun_one_done", 64'(done_cnt), 64'd1);
    check("midrun_result", Result, {32'd2, 32'd14});

    // Back-to-back: Start held high through DONE is accepted on first IDLE edge
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; A = 32'd6; B = 32'd7;
    repeat (34) @(posedge Clock);
    #1;
    check("b2b_done", {63'd0, Done}, 64'd1);
    check("b2b_result", Result, 64'd42);
    @(posedge Clock); #1;
    check("b2b_idle", {63'd0, Busy}, 64'd0);
    @(posedge Clock); #1;
    check("b2b_reaccept", {63'd0, Busy}, 64'd1);
    Start = 1'b0;
    repeat (36) @(posedge Clock);
    #1;
    check("b2b_result2", Result, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle signed multiply/divide unit upstream of the 64-bit Z register.
- Its 64-bit Result feeds the Z register's ALU_Result input, muxed with the single-cycle ALU by the control unit.
- The control unit asserts Zin on the cycle Done is high.
- MUL uses radix-2 Booth; DIV uses restoring division on magnitudes with sign fix-up. Result layout is {HI, LO}.

Parameters:
- WIDTH, 32, operand width; Result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Clear  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  1  0 = MUL, 1 = DIV.
- A  input  WIDTH  multiplicand / dividend, signed.
- B  input  WIDTH  multiplier / divisor, signed.
- Busy  output  1  high from the accept edge until Done drops.
- Done  output  1  one-cycle pulse; Result valid.
- DivZero  output  1  set with Done when Op=DIV and B=0; held until next accept.
- Result  output  2*WIDTH  MUL: full signed product. DIV: {remainder, quotient}.

Behaviour:
- Reset:
  - Clear is checked on the rising edge of Clock and has priority over everything.
  - Reset state: IDLE; Busy=0, Done=0, DivZero=0, Result=0; counter and internal registers 0.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- Accept (edge E0):
  - In IDLE with Start=1: latch A, B and Op, clear the counter, go to RUN, Busy=1.
  - Start in any other state is ignored and not queued.
  - Operand changes after E0 have no effect.
- RUN: one iteration per edge for exactly WIDTH edges (E1..E32); the edge where the counter reaches WIDTH-1 moves to FIX.
- MUL iteration (Booth):
  - Accumulator {P_hi, P_lo, q_-1}, with P_lo initialised to B and q_-1 to 0.
  - Examine {P_lo[0], q_-1}: 01 adds A to P_hi, 10 subtracts A from P_hi, 00/11 do nothing.
  - Then arithmetic right shift of the whole accumulator.
  - P_hi is computed WIDTH+1 bits wide so that A = -2^31 does not overflow.
- DIV iteration (restoring, unsigned magnitudes |A|, |B|):
  - Shift {R, Q} left by 1 and trial-subtract |B| from R.
  - If the trial is non-negative, keep it and set Q[0]=1; otherwise restore R.
- FIX (E33), Result register written:
  - MUL: Result = accumulator.
  - DIV: quotient is negated if sign(A) != sign(B); remainder takes the sign of A (truncation toward zero).
  - Go to DONE, set Done=1.
- DONE: Done=1 and Busy=1 for exactly that one cycle; next edge returns to IDLE, Done=0, Busy=0.
- Latency: Done is visible in the cycle following E33, i.e. 33 edges after accept. It is identical for MUL, DIV and divide-by-zero.
- Result holds its value until FIX of the next operation or Clear. It is not cleared on accept.
- Divide by zero: iterations still run with no effect; at FIX, Result = {A, {WIDTH{1'b1}}}, DivZero=1.
- Overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0, with no flag.
- Clear mid-operation (RUN/FIX/DONE): next state IDLE, no Done pulse, Result=0.
- Start and Clear on the same edge: Clear wins and the request is dropped.
- Back-to-back: a Start held high through DONE is accepted on the first edge seen in IDLE.

Decomposition:
- Shared package mul_div_pkg holds:
  - state encoding (IDLE, RUN, FIX, DONE);
  - OP_MUL/OP_DIV constants;
  - WIDTH default.
- Sub-module mul_div_iter: purely combinational single-iteration datapath, shared by MUL and DIV.
  - Inputs: Op, accumulator state, latched operand magnitude.
  - Output: next accumulator state.
  - The top level holds the FSM, counter and registers.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> Done at accept+33, Result=64'hFFFFFFFF_FFFFFFEB, DivZero=0, Busy high for 34 cycles.
- MUL A=B=0x80000000 -> Result=64'h40000000_00000000; A=0xFFFFFFFF, B=0x00000001 -> 64'hFFFFFFFF_FFFFFFFF.
- DIV A=-7, B=2 -> Result={32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quot -3); DIV A=100, B=7 -> {32'd2, 32'd14}.
- DIV A=5, B=0 -> Done at accept+33, Result={32'h00000005, 32'hFFFFFFFF}, DivZero=1; a following MUL clears DivZero at accept.
- DIV A=0x80000000, B=0xFFFFFFFF -> Result={32'h0, 32'h80000000}, DivZero=0.
- Clear asserted 10 cycles into a MUL -> next edge Busy=0, Result=0, no Done. Start pulsed mid-RUN of another op -> ignored; exactly one Done pulse observed.
